// File: rtl/tx_bit_serialiser.sv
// Byte-to-bit serialiser for the tx path: shifts frame bytes out LSB first and
// optionally appends a CRC_A (ISO 14443-A) trailer, low byte first.
module tx_bit_serialiser #(
   parameter logic [15:0] CRC_INIT = 16'h6363,
   parameter logic [15:0] CRC_POLY = 16'h8408
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_data_valid,
   input  logic [2:0] in_data_bits,
   input  logic       in_append_crc,
   output logic       in_req,
   output logic       out_bit,
   output logic       out_bit_valid,
   output logic       out_bit_last,
   input  logic       out_bit_req
);

   typedef enum logic [1:0] {StIdle, StData, StCrc} state_e;

   state_e      state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] crc_q, crc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        more_q, more_d;
   logic        append_q, append_d;
   logic        full_q, full_d;
   logic        req_q, req_d;
   logic        samp_q, samp_d;
   logic        valid_q, valid_d;

   logic        consume;
   logic        crc_fb;
   logic [15:0] crc_step;

   assign consume  = valid_q & out_bit_req;
   assign crc_fb   = crc_q[0] ^ shift_q[0];
   assign crc_step = (crc_q >> 1) ^ (crc_fb ? CRC_POLY : 16'h0000);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      crc_d    = crc_q;
      cnt_d    = cnt_q;
      more_d   = more_q;
      append_d = append_q;
      full_d   = full_q;
      valid_d  = valid_q;
      req_d    = 1'b0;
      samp_d   = req_q;
      unique case (state_q)
         StIdle: begin
            if (in_data_valid) begin
               shift_d  = in_data;
               append_d = in_append_crc;
               crc_d    = CRC_INIT;
               req_d    = 1'b1;
               valid_d  = 1'b0;
               state_d  = StData;
            end
         end
         StData: begin
            // The source answers an in_req one cycle later; that answer says
            // whether the byte being shifted is the last one.
            if (samp_q) begin
               more_d  = in_data_valid;
               full_d  = in_data_valid | (in_data_bits == 3'd0);
               cnt_d   = (in_data_valid || in_data_bits == 3'd0) ? 5'd8 : {2'b00, in_data_bits};
               valid_d = 1'b1;
            end else if (consume) begin
               shift_d = shift_q >> 1;
               crc_d   = crc_step;
               cnt_d   = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  if (more_q) begin
                     shift_d = in_data;
                     req_d   = 1'b1;
                     valid_d = 1'b0;
                  end else if (append_q && full_q) begin
                     cnt_d   = 5'd16;
                     state_d = StCrc;
                  end else begin
                     valid_d = 1'b0;
                     state_d = StIdle;
                  end
               end
            end
         end
         StCrc: begin
            if (consume) begin
               crc_d = crc_q >> 1;
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  valid_d = 1'b0;
                  state_d = StIdle;
               end
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         shift_q  <= 8'h00;
         crc_q    <= CRC_INIT;
         cnt_q    <= 5'd0;
         more_q   <= 1'b0;
         append_q <= 1'b0;
         full_q   <= 1'b0;
         req_q    <= 1'b0;
         samp_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         crc_q    <= crc_d;
         cnt_q    <= cnt_d;
         more_q   <= more_d;
         append_q <= append_d;
         full_q   <= full_d;
         req_q    <= req_d;
         samp_q   <= samp_d;
         valid_q  <= valid_d;
      end
   end

   assign in_req        = req_q;
   assign out_bit_valid = valid_q;
   assign out_bit       = (state_q == StCrc)  ? crc_q[0] :
                          (state_q == StData) ? shift_q[0] : 1'b0;
   assign out_bit_last  = valid_q & (cnt_q == 5'd1) &
                          ((state_q == StCrc) |
                           ((state_q == StData) & ~more_q & ~(append_q & full_q)));

endmodule

// File: tb/tb_tx_bit_serialiser.sv
// Directed bench for tx_bit_serialiser: a byte source answering in_req and a
// bit sink that records every consumed bit, its last flag and in_req timing.
module tb_tx_bit_serialiser;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_data_valid;
   logic [2:0] in_data_bits;
   logic       in_append_crc;
   logic       in_req;
   logic       out_bit;
   logic       out_bit_valid;
   logic       out_bit_last;
   logic       out_bit_req;

   int total = 0;
   int bad   = 0;

   logic [7:0] src_bytes [4];
   int         src_len;
   int         src_idx;
   bit         src_active = 1'b0;
   bit         throttle   = 1'b0;
   int         gap_left   = 0;

   bit         bits_q  [$];
   bit         lasts_q [$];
   int         gaps_q  [$];
   int         req_count = 0;
   int         cyc       = 0;
   int         req_cyc   = 0;
   bit         prev_valid = 1'b0;
   bit         done       = 1'b0;
   bit         post_pending = 1'b0;
   bit         post_seen    = 1'b0;
   logic       post_valid;

   tx_bit_serialiser dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_data_valid (in_data_valid),
      .in_data_bits  (in_data_bits),
      .in_append_crc (in_append_crc),
      .in_req        (in_req),
      .out_bit       (out_bit),
      .out_bit_valid (out_bit_valid),
      .out_bit_last  (out_bit_last),
      .out_bit_req   (out_bit_req)
   );

   always #5 clk = ~clk;

   // Source and sink both act on the falling edge, away from the DUT's edge.
   always @(negedge clk) begin
      cyc++;
      if (in_req) begin
         req_count++;
         req_cyc = cyc;
         if (src_active) begin
            src_idx++;
            if (src_idx < src_len) in_data = src_bytes[src_idx];
            else begin
               in_data_valid = 1'b0;
               src_active    = 1'b0;
            end
         end
      end
      if (out_bit_valid && !prev_valid) gaps_q.push_back(cyc - req_cyc);
      prev_valid = out_bit_valid;
      if (post_pending) begin
         post_valid   = out_bit_valid;
         post_seen    = 1'b1;
         post_pending = 1'b0;
      end
      if (!throttle) out_bit_req = 1'b1;
      else if (gap_left > 0) begin
         out_bit_req = 1'b0;
         gap_left--;
      end else begin
         int r;
         r = $urandom_range(0, 15);
         if (r == 0) gap_left = 20;
         out_bit_req = (r < 7);
      end
      if (out_bit_valid && out_bit_req) begin
         bits_q.push_back(out_bit);
         lasts_q.push_back(out_bit_last);
         if (out_bit_last) begin
            done         = 1'b1;
            post_pending = 1'b1;
         end
      end
   end

   function automatic int stream_errs(input logic [7:0] e0, input logic [7:0] e1,
                                      input logic [7:0] e2, input logic [7:0] e3,
                                      input int nbits);
      logic [7:0] e [4];
      int errs;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      errs = 0;
      if (bits_q.size() != nbits) return nbits + 1;
      for (int i = 0; i < nbits; i++) if (bits_q[i] !== e[i/8][i%8]) errs++;
      return errs;
   endfunction

   function automatic int last_count();
      int n;
      n = 0;
      foreach (lasts_q[i]) if (lasts_q[i]) n++;
      return n;
   endfunction

   task automatic start_frame(input int n, input logic [2:0] nbits, input logic app,
                              input bit thr, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
      @(posedge clk);
      #1;
      bits_q.delete(); lasts_q.delete(); gaps_q.delete();
      req_count = 0; done = 1'b0; post_seen = 1'b0; gap_left = 0;
      throttle  = thr;
      src_bytes[0] = b0; src_bytes[1] = b1; src_bytes[2] = b2; src_bytes[3] = 8'h00;
      src_len = n; src_idx = 0; src_active = 1'b1;
      in_data = b0; in_data_bits = nbits; in_append_crc = app; in_data_valid = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (!done && t < 4000) begin
         @(posedge clk);
         t++;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s timeout: got no last bit, required one within 4000 cycles", name);
      end
      repeat (4) @(posedge clk);
      in_append_crc = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_data_valid = 1'b0; in_data = 8'h00; in_data_bits = 3'd0;
      in_append_crc = 1'b0; out_bit_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({in_req, out_bit_valid, out_bit_last, out_bit} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_outputs got=%b required=0000",
                  {in_req, out_bit_valid, out_bit_last, out_bit});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      total++;
      if (req_count !== 0) begin
         bad++;
         $display("FAIL reset_idle_req got=%0d required=0", req_count);
      end
   endtask

   task automatic test_short_frame();
      start_frame(1, 3'd7, 1'b1, 1'b0, 8'h26, 8'h00, 8'h00);
      wait_done("short");
      total++;
      if (stream_errs(8'h26, 8'h00, 8'h00, 8'h00, 7) !== 0) begin
         bad++;
         $display("FAIL short_stream got %0d bits, required 7 bits 0110010 LSB first",
                  bits_q.size());
      end
      total++;
      if (last_count() !== 1 || lasts_q[lasts_q.size()-1] !== 1'b1) begin
         bad++;
         $display("FAIL short_last got %0d last flags, required 1 on bit 7", last_count());
      end
      total++;
      if (req_count !== 1) begin
         bad++;
         $display("FAIL short_req got=%0d required=1", req_count);
      end
   endtask

   task automatic test_zero_crc();
      start_frame(2, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      wait_done("zero_crc");
      total++;
      if (stream_errs(8'h00, 8'h00, 8'hA0, 8'h1E, 32) !== 0) begin
         bad++;
         $display("FAIL zero_crc_stream got %0d bits, required 00 00 A0 1E (32 bits)",
                  bits_q.size());
      end
      total++;
      if (last_count() !== 1 || lasts_q.size() != 32 || lasts_q[31] !== 1'b1) begin
         bad++;
         $display("FAIL zero_crc_last got %0d flags over %0d bits, required 1 on bit 32",
                  last_count(), lasts_q.size());
      end
      total++;
      if (!post_seen || post_valid !== 1'b0) begin
         bad++;
         $display("FAIL zero_crc_idle valid after last got=%b required=0", post_valid);
      end
   endtask

   task automatic test_crc_bytes(input bit thr, input string name);
      start_frame(2, 3'd0, 1'b1, thr, 8'h12, 8'h34, 8'h00);
      wait_done(name);
      total++;
      if (stream_errs(8'h12, 8'h34, 8'h26, 8'hCF, 32) !== 0) begin
         bad++;
         $display("FAIL %s_stream got %0d bits, required 12 34 26 CF (32 bits)",
                  name, bits_q.size());
      end
      total++;
      if (req_count !== 2) begin
         bad++;
         $display("FAIL %s_req got=%0d required=2", name, req_count);
      end
      total++;
      if (gaps_q.size() != 2 || gaps_q[0] !== 2 || gaps_q[1] !== 2) begin
         bad++;
         $display("FAIL %s_bubble got %0d valid rises, required 2 each 2 cycles after in_req",
                  name, gaps_q.size());
      end
   endtask

   task automatic test_mid_reset();
      int t, saved;
      start_frame(3, 3'd0, 1'b1, 1'b0, 8'hAA, 8'h55, 8'hC3);
      t = 0;
      while (bits_q.size() < 5 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      rst = 1'b1; src_active = 1'b0; in_data_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({in_req, out_bit_valid, out_bit_last, out_bit} !== 4'b0000) begin
         bad++;
         $display("FAIL mid_reset_outputs got=%b required=0000",
                  {in_req, out_bit_valid, out_bit_last, out_bit});
      end
      saved = req_count;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      total++;
      if (req_count !== saved || out_bit_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_quiet got req=%0d valid=%b required req=%0d valid=0",
                  req_count, out_bit_valid, saved);
      end
   endtask

   task automatic test_no_crc();
      start_frame(2, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00);
      wait_done("no_crc");
      total++;
      if (stream_errs(8'hFF, 8'h01, 8'h00, 8'h00, 16) !== 0) begin
         bad++;
         $display("FAIL no_crc_stream got %0d bits, required FF 01 (16 bits)", bits_q.size());
      end
      total++;
      if (last_count() !== 1 || lasts_q.size() != 16 || lasts_q[15] !== 1'b1) begin
         bad++;
         $display("FAIL no_crc_last got %0d flags over %0d bits, required 1 on bit 16",
                  last_count(), lasts_q.size());
      end
      total++;
      if (!post_seen || post_valid !== 1'b0) begin
         bad++;
         $display("FAIL no_crc_idle valid after last got=%b required=0", post_valid);
      end
   endtask

   initial begin
      test_reset();
      test_short_frame();
      test_zero_crc();
      test_crc_bytes(1'b0, "crc_1234");
      test_crc_bytes(1'b1, "throttled");
      test_mid_reset();
      test_no_crc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tx_bit_serialiser.md
TX_BIT_SERIALISER -- requirements
Module: tx_bit_serialiser

Interface
REQ-001 SHALL have parameter CRC_INIT, default 16'h6363, CRC_A preset value.
REQ-002 SHALL have parameter CRC_POLY, default 16'h8408, reflected CRC_A polynomial (x^16+x^12+x^5+1).
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  byte from the tx router; LSB is sent first.
REQ-006 SHALL have port in_data_valid  input  1  source has a byte on in_data.
REQ-007 SHALL have port in_data_bits  input  3  valid bits in the final byte; 0 means 8.
REQ-008 SHALL have port in_append_crc  input  1  append CRC_A to this frame.
REQ-009 SHALL have port in_req  output  1  one-cycle pulse; source presents the next byte, or drops in_data_valid, on the following cycle.
REQ-010 SHALL have port out_bit  output  1  current serial bit.
REQ-011 SHALL have port out_bit_valid  output  1  out_bit holds an unconsumed bit.
REQ-012 SHALL have port out_bit_last  output  1  out_bit is the final bit of the frame.
REQ-013 SHALL have port out_bit_req  input  1  downstream consumes the current bit this cycle.

Function
REQ-014 SHALL implement the states IDLE, DATA and CRC.
REQ-015 In IDLE, when in_data_valid=1: SHALL load in_data into the shift register, latch in_append_crc, preset crc to CRC_INIT, pulse in_req for 1 cycle and enter DATA.
REQ-016 On the cycle after each in_req pulse, SHALL sample in_data_valid into more_bytes.
- more_bytes=1: the current byte carries 8 bits.
- more_bytes=0: the current byte carries in_data_bits bits (0 means 8) and is the last byte.
- in_data_bits SHALL be sampled on that same cycle.
REQ-017 out_bit_valid SHALL be 1 in DATA from the cycle after more_bytes is sampled, and SHALL be 1 throughout CRC.
REQ-018 out_bit SHALL equal shift_reg[0] in DATA and crc[0] in CRC.
REQ-019 Bits SHALL be consumed only when out_bit_req=1 and out_bit_valid=1. Each consumed bit:
- shifts the register right by one;
- updates crc per bit: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? CRC_POLY : 0).
REQ-020 out_bit_req while out_bit_valid=0 SHALL be ignored.
REQ-021 Last bit of a byte consumed with more_bytes=1: SHALL load in_data, pulse in_req in the next cycle, and hold out_bit_valid=0 until more_bytes is re-sampled (2-cycle bubble per byte).
REQ-022 Last bit of the last byte consumed:
- CRC is appended only if latched append_crc=1 and the final byte was full (8 bits); the block then enters CRC with 16 bits, low byte first, LSB first.
- Otherwise the block returns to IDLE.
REQ-023 In CRC, crc SHALL shift right one bit per consumed bit with no further polynomial feedback; there is no final inversion.
REQ-024 out_bit_last SHALL be 1 on the final data bit when no CRC is appended, or on CRC bit 15; it SHALL be 0 at all other times.
REQ-025 After the final bit is consumed, SHALL return to IDLE with out_bit_valid=0. A new frame SHALL NOT start in that same cycle.
REQ-026 in_data_valid changes between in_req pulses SHALL be ignored.
REQ-027 in_append_crc SHALL be sampled only at frame start.
REQ-028 A short frame (a single byte with in_data_bits≠0) SHALL never get a CRC, even when append_crc is set.

Reset
REQ-029 With rst=1 at a clock edge:
- SHALL force IDLE, in_req=0, out_bit_valid=0, out_bit_last=0, out_bit=0;
- shift register 0, crc=CRC_INIT, more_bytes=0.
REQ-030 A reset mid-frame SHALL abandon the frame and pulse no further in_req. The frame restarts only from IDLE after rst falls.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Single byte 0x26, in_data_bits=7, append_crc=1 -> bits 0,1,1,0,0,1,0; last on bit 7; no CRC; exactly 1 in_req.
- Bytes 0x00,0x00, append_crc=1 -> 16 zero bits, then CRC bytes 0xA0 then 0x1E, LSB first; 32 bits total; out_bit_last only on bit 32.
- Bytes 0x12,0x34, append_crc=1 -> CRC bytes 0x26 then 0xCF; exactly 2 in_req pulses, one per byte, each followed by a 2-cycle bubble.
- Random out_bit_req throttling (including long gaps and req while invalid) -> serial stream identical to the unthrottled run; no bit lost or duplicated.
- rst asserted after 5 bits of a 3-byte frame -> all outputs 0 the next cycle; no in_req pulse until a new in_data_valid after reset.
- Bytes 0xFF,0x01, append_crc=0 -> 16 data bits, out_bit_last on bit 16, immediate return to IDLE.
